// File: rtl/bit_set_pkg.sv
// Shared types and defaults for the round-robin bit-set scheduler.
package bit_set_pkg;

  localparam int unsigned DefaultM = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/bit_set.sv
// Sets bit arg_b_i of arg_a_i; flags err_o when the index is out of range.
module bit_set #(
  parameter int unsigned M    = 8,
  parameter int unsigned IdxW = 3
) (
  input  logic [M-1:0]    arg_a_i,
  input  logic [IdxW-1:0] arg_b_i,
  output logic [M-1:0]    y_o,
  output logic            err_o
);

  always_comb begin
    err_o = (32'(arg_b_i) >= M);
    y_o   = err_o ? arg_a_i : (arg_a_i | (M'(1) << arg_b_i));
  end

endmodule

// File: rtl/bit_set_sched.sv
// Two-requester round-robin scheduler that sets every mask bit of a base operand,
// one bit per cycle, through a single shared bit_set datapath.
module bit_set_sched
  import bit_set_pkg::*;
#(
  parameter int unsigned M = DefaultM
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [1:0]             i_req_vld,
  output logic [1:0]             o_req_rdy,
  input  logic [M-1:0]           i_argA_0,
  input  logic [M-1:0]           i_argA_1,
  input  logic [M-1:0]           i_mask_0,
  input  logic [M-1:0]           i_mask_1,
  output logic                   o_rsp_vld,
  input  logic                   i_rsp_rdy,
  output logic                   o_rsp_id,
  output logic [M-1:0]           o_y,
  output logic [$clog2(M+1)-1:0] o_cnt,
  output logic                   o_err,
  output logic                   o_busy
);

  localparam int unsigned IdxW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned CntW = $clog2(M + 1);

  state_e          state_q, state_d;
  logic [M-1:0]    acc_q, acc_d;
  logic [M-1:0]    rem_q, rem_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  req_id_t         id_q, id_d;
  req_id_t         rr_q, rr_d;

  req_id_t         gnt;
  logic            accept;
  logic [M-1:0]    sel_arg, sel_mask;
  logic [IdxW-1:0] idx;
  logic [M-1:0]    bs_y;
  logic            bs_err;

  // rr_q names the requester favoured when both are valid.
  always_comb begin
    case (i_req_vld)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      default: gnt = rr_q;
    endcase
    accept    = (state_q == StIdle) && !i_rst && (|i_req_vld);
    o_req_rdy = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    sel_arg   = gnt ? i_argA_1 : i_argA_0;
    sel_mask  = gnt ? i_mask_1 : i_mask_0;
  end

  // Lowest set bit of the remaining mask.
  always_comb begin
    idx = '0;
    for (int i = int'(M) - 1; i >= 0; i--) begin
      if (rem_q[i]) idx = IdxW'(i);
    end
  end

  bit_set #(
    .M   (M),
    .IdxW(IdxW)
  ) u_bit_set (
    .arg_a_i(acc_q),
    .arg_b_i(idx),
    .y_o    (bs_y),
    .err_o  (bs_err)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    id_d    = id_q;
    rr_d    = rr_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          acc_d   = sel_arg;
          rem_d   = sel_mask;
          id_d    = gnt;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = (sel_mask == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        acc_d      = bs_y;
        rem_d[idx] = 1'b0;
        cnt_d      = cnt_q + CntW'(1);
        err_d      = err_q | bs_err;
        if (rem_d == '0) state_d = StDone;
      end
      StDone: begin
        if (i_rsp_rdy) begin
          state_d = StIdle;
          rr_d    = ~id_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      id_q    <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    o_rsp_vld = (state_q == StDone);
    o_y       = o_rsp_vld ? acc_q : '0;
    o_cnt     = o_rsp_vld ? cnt_q : '0;
    o_err     = o_rsp_vld ? err_q : 1'b0;
    o_rsp_id  = o_rsp_vld ? id_q : 1'b0;
    o_busy    = (state_q != StIdle);
  end

endmodule

// File: tb/tb_bit_set_sched.sv
// Randomized self-checking bench for bit_set_sched against a transaction-level model.
module tb_bit_set_sched;

  localparam int unsigned M    = 8;
  localparam int unsigned CntW = $clog2(M + 1);

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic [1:0]      i_req_vld;
  logic [1:0]      o_req_rdy;
  logic [M-1:0]    i_argA_0, i_argA_1, i_mask_0, i_mask_1;
  logic            o_rsp_vld;
  logic            i_rsp_rdy;
  logic            o_rsp_id;
  logic [M-1:0]    o_y;
  logic [CntW-1:0] o_cnt;
  logic            o_err;
  logic            o_busy;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned rr_model = 0;

  always #5 i_clk = ~i_clk;

  bit_set_sched #(.M(M)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_req_vld(i_req_vld),
    .o_req_rdy(o_req_rdy),
    .i_argA_0 (i_argA_0),
    .i_argA_1 (i_argA_1),
    .i_mask_0 (i_mask_0),
    .i_mask_1 (i_mask_1),
    .o_rsp_vld(o_rsp_vld),
    .i_rsp_rdy(i_rsp_rdy),
    .o_rsp_id (o_rsp_id),
    .o_y      (o_y),
    .o_cnt    (o_cnt),
    .o_err    (o_err),
    .o_busy   (o_busy)
  );

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rsp_vld"}, o_rsp_vld, 0);
    check({tag, "_y"}, o_y, 0);
    check({tag, "_cnt"}, o_cnt, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_id"}, o_rsp_id, 0);
  endtask

  task automatic check_rsp(input string tag, input int unsigned y, input int unsigned cnt,
                           input int unsigned id);
    check({tag, "_rsp_vld"}, o_rsp_vld, 1);
    check({tag, "_y"}, o_y, y);
    check({tag, "_cnt"}, o_cnt, cnt);
    check({tag, "_id"}, o_rsp_id, id);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_busy"}, o_busy, 1);
    check({tag, "_req_rdy"}, o_req_rdy, 0);
  endtask

  // Entered just after a rising edge with the DUT idle; returns the same way.
  task automatic run_txn(input string tag, input logic [1:0] vld,
                         input logic [M-1:0] a0, input logic [M-1:0] m0,
                         input logic [M-1:0] a1, input logic [M-1:0] m1,
                         input int unsigned hold);
    int unsigned g, pop, lat, exp_y;
    g     = (vld == 2'b11) ? rr_model : (vld[1] ? 1 : 0);
    exp_y = (g == 1) ? int'(a1 | m1) : int'(a0 | m0);
    pop   = (g == 1) ? $countones(m1) : $countones(m0);
    i_req_vld = vld;
    i_argA_0  = a0;
    i_mask_0  = m0;
    i_argA_1  = a1;
    i_mask_1  = m1;
    @(negedge i_clk);
    check({tag, "_grant"}, o_req_rdy, (g == 1) ? 2 : 1);
    check({tag, "_idle_busy"}, o_busy, 0);
    @(posedge i_clk);
    #1;
    // Post-accept inputs must not matter.
    i_req_vld = 2'($urandom);
    i_argA_0  = M'($urandom);
    i_argA_1  = M'($urandom);
    i_mask_0  = M'($urandom);
    i_mask_1  = M'($urandom);
    lat = 1;
    @(negedge i_clk);
    if (pop > 0) begin
      check({tag, "_run_y"}, o_y, 0);
      check({tag, "_run_busy"}, o_busy, 1);
      check({tag, "_run_req_rdy"}, o_req_rdy, 0);
    end
    while (!o_rsp_vld && lat < 2 * M + 4) begin
      @(negedge i_clk);
      lat++;
    end
    // Cycle T+1+popcount relative to the accept cycle T.
    check({tag, "_latency"}, lat, 1 + pop);
    check_rsp(tag, exp_y, pop, g);
    for (int w = 0; w < int'(hold); w++) begin
      @(negedge i_clk);
      check_rsp({tag, "_hold"}, exp_y, pop, g);
    end
    i_rsp_rdy = 1'b1;
    @(posedge i_clk);
    #1;
    i_rsp_rdy = 1'b0;
    i_req_vld = 2'b00;
    rr_model  = (g == 1) ? 0 : 1;
    @(negedge i_clk);
    check({tag, "_after_busy"}, o_busy, 0);
    check({tag, "_after_rsp_vld"}, o_rsp_vld, 0);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic [1:0]   v;
    logic [M-1:0] a0, m0, a1, m1;
    i_rst     = 1'b1;
    i_req_vld = 2'b11;
    i_argA_0  = '0;
    i_argA_1  = '0;
    i_mask_0  = '0;
    i_mask_1  = '0;
    i_rsp_rdy = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_req_rdy", o_req_rdy, 0);
    check("rst_busy", o_busy, 0);
    check_idle_outputs("rst");
    i_req_vld = 2'b00;
    i_rst     = 1'b0;
    @(posedge i_clk);
    #1;

    run_txn("zero_mask", 2'b01, 8'h07, 8'h00, 8'h00, 8'h00, 0);
    run_txn("two_bits", 2'b10, 8'h00, 8'h00, 8'h00, 8'h81, 0);
    run_txn("both_a", 2'b11, 8'h10, 8'h01, 8'h00, 8'hF0, 0);
    run_txn("both_b", 2'b11, 8'h10, 8'h01, 8'h00, 8'hF0, 0);
    run_txn("both_c", 2'b11, 8'h10, 8'h01, 8'h00, 8'hF0, 0);
    run_txn("stall", 2'b01, 8'h5A, 8'h0C, 8'h00, 8'h00, 5);
    run_txn("full", 2'b10, 8'h00, 8'h00, 8'hFF, 8'hFF, 0);

    for (int t = 0; t < 40; t++) begin
      v  = 2'($urandom_range(1, 3));
      a0 = M'($urandom);
      a1 = M'($urandom);
      m0 = ($urandom_range(0, 5) == 0) ? '0 : M'($urandom);
      m1 = ($urandom_range(0, 5) == 0) ? '0 : M'($urandom & $urandom);
      run_txn("rand", v, a0, m0, a1, m1, $urandom_range(0, 3));
    end

    // Reset in the 3rd RUN cycle of a full mask drops the operation.
    i_req_vld = 2'b01;
    i_argA_0  = 8'hFF;
    i_mask_0  = 8'hFF;
    @(posedge i_clk);
    #1;
    i_req_vld = 2'b11;
    repeat (2) @(posedge i_clk);
    #2;
    check("pre_rst_busy", o_busy, 1);
    i_rst = 1'b1;
    #1;
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_req_rdy", o_req_rdy, 0);
    check_idle_outputs("mid_rst");
    repeat (2) @(negedge i_clk);
    check("mid_rst_hold_busy", o_busy, 0);
    i_req_vld = 2'b00;
    i_rst     = 1'b0;
    rr_model  = 0;
    for (int c = 0; c < int'(M) + 3; c++) begin
      @(negedge i_clk);
      check("post_rst_no_rsp", o_rsp_vld, 0);
    end
    @(posedge i_clk);
    #1;
    run_txn("post_rst_both", 2'b11, 8'h21, 8'h42, 8'h00, 8'h03, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bit_set_sched.md
BIT_SET_SCHED -- requirements
Module: bit_set_sched

Interface
REQ-001 SHALL have parameter M, default 8, giving the operand width in bits.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port i_req_vld, input, 2 bits: request valid, one bit per requester r in {0,1}.
REQ-005 SHALL have port o_req_rdy, output, 2 bits: request ready, one bit per requester.
REQ-006 SHALL have ports i_argA_0 and i_argA_1, input, M bits each: base operand per requester.
REQ-007 SHALL have ports i_mask_0 and i_mask_1, input, M bits each: bit positions to set per requester.
REQ-008 SHALL have port o_rsp_vld, output, 1 bit: response valid.
REQ-009 SHALL have port i_rsp_rdy, input, 1 bit: response accepted by consumer.
REQ-010 SHALL have port o_rsp_id, output, 1 bit: index of the requester that owns the response.
REQ-011 SHALL have port o_y, output, M bits: result operand.
REQ-012 SHALL have port o_cnt, output, $clog2(M+1) bits: number of bit_set operations performed.
REQ-013 SHALL have port o_err, output, 1 bit: OR of bit_set ERROR over the whole operation.
REQ-014 SHALL have port o_busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 In IDLE, SHALL grant one requester round-robin; o_req_rdy is high only for the granted requester, and only in IDLE.
REQ-017 Grant rules: single requester valid -> that requester; both valid -> the requester not granted last; after reset, requester 0 has priority.
REQ-018 On accept (vld & rdy), SHALL latch: acc <= argA, rem <= mask, id <= r, cnt <= 0, err <= 0.
REQ-019 On accept, SHALL move to DONE if mask == 0, else to RUN.
REQ-020 In RUN, each cycle SHALL take idx = lowest set bit of rem and drive the bit_set instance with argA = acc and argB = idx.
REQ-021 In each RUN cycle, SHALL update acc <= o_y, clear rem[idx], increment cnt, and OR ERROR into err.
REQ-022 SHALL leave RUN for DONE in the cycle where rem becomes zero.
REQ-023 Latency: accept at cycle T -> o_rsp_vld asserted at T+1+popcount(mask).
REQ-024 Bits already set in argA SHALL still be processed and counted, so o_cnt == popcount(mask).
REQ-025 In DONE, o_rsp_vld = 1 and o_y = acc, o_cnt, o_err, o_rsp_id SHALL all hold stable until i_rsp_rdy.
REQ-026 On response handshake, SHALL return to IDLE and update the round-robin pointer to favour the other requester.
REQ-027 No new request SHALL be accepted in the handshake cycle; the earliest next accept is the following cycle.
REQ-028 Outside DONE, o_rsp_vld SHALL be 0; o_y, o_cnt, o_err, o_rsp_id SHALL read 0.
REQ-029 Requester inputs SHALL be ignored while not granted and are not sampled after accept.

Reset
REQ-030 On i_rst, SHALL immediately (asynchronously) enter IDLE and clear acc, rem, cnt, err and id.
REQ-031 On i_rst, SHALL set the round-robin pointer to favour requester 0.
REQ-032 While i_rst is high, all outputs SHALL be 0, including o_req_rdy.
REQ-033 Reset mid-RUN or mid-DONE SHALL drop the in-flight operation without producing a response.

Structure
REQ-034 Package bit_set_pkg SHALL hold the default M, the FSM state enum, and the requester-id type.
REQ-035 SHALL instantiate exactly one bit_set sub-module as the shared datapath; no other bit arithmetic except priority encode and clear of rem.

Verification
REQ-036 After reset, req0 argA=0x07 mask=0x00 -> accepted; next cycle rsp_vld=1, y=0x07, cnt=0, id=0, err=0.
REQ-037 req1 argA=0x00 mask=0x81 -> 2 RUN cycles (idx 0 then 7); rsp_vld at T+3, y=0x81, cnt=2, id=1.
REQ-038 Both valid after reset: r0 argA=0x10 mask=0x01, r1 argA=0x00 mask=0xF0 -> first y=0x11 id=0, then y=0xF0 cnt=4 id=1; next simultaneous request -> r0 granted.
REQ-039 i_rsp_rdy held 0 for 5 cycles in DONE -> outputs stable, o_req_rdy=00, o_busy=1; rdy=1 -> IDLE next cycle.
REQ-040 argA=0xFF mask=0xFF -> 8 RUN cycles, y=0xFF, cnt=8, err=0.
REQ-041 i_rst asserted in the 3rd RUN cycle of mask=0xFF -> outputs 0 immediately, IDLE, no response.
